// File: rtl/disp_ctrl_if.sv
// Handshake/bus bundle between disp_ctrl, the calculator core (keypad/ALU
// requesters) and the shared binary->BCD->7-seg converter.
interface disp_ctrl_if;
  logic        key_req;
  logic [13:0] key_num;
  logic        key_ack;
  logic        alu_req;
  logic [13:0] alu_num;
  logic        alu_err;
  logic        alu_ack;
  logic [13:0] cv_num;
  logic        cv_convert;
  logic        cv_error;
  logic        cv_done;
  logic [31:0] cv_digits;

  // Requesters and converter side.
  modport master (
    output key_req, key_num, alu_req, alu_num, alu_err, cv_done, cv_digits,
    input  key_ack, alu_ack, cv_num, cv_convert, cv_error
  );

  // Sequencer side.
  modport slave (
    input  key_req, key_num, alu_req, alu_num, alu_err, cv_done, cv_digits,
    output key_ack, alu_ack, cv_num, cv_convert, cv_error
  );
endinterface

// File: rtl/disp_ctrl.sv
// Arbitrates keypad/ALU jobs onto the shared 7-seg converter, latches the
// resulting segment word and scans it onto a 4-digit common-cathode display.
module disp_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned TIMEOUT  = 32,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  disp_ctrl_if.slave      bus,
  output logic [7:0]      seg,
  output logic [3:0]      an,
  output logic            busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic GRANT_KEY = 1'b0;

  localparam logic [31:0] WORD_ZERO = 32'h3F3F3F3F;
  localparam logic [31:0] WORD_ERR  = 32'h763D507C;
  localparam logic [31:0] WORD_DASH = 32'h40404040;
  localparam logic [7:0]  SEG_ZERO  = 8'h3F;

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state;
  logic          last_grant;
  logic [31:0]   shown;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic          grant_any;
  logic          grant_alu;
  logic [3:0]    blank;
  logic [7:0]    digit;
  logic [7:0]    seg_cur;

  assign busy         = (state != IDLE);
  assign bus.cv_error = 1'b0;

  // An ack still high means that requester has not yet seen it and dropped
  // its request, so hold off re-arbitrating for that cycle.
  always_comb begin
    grant_any = (bus.key_req || bus.alu_req) && !bus.key_ack && !bus.alu_ack;
    grant_alu = bus.alu_req && (!bus.key_req || (last_grant == GRANT_KEY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= GRANT_KEY;
      shown          <= WORD_ZERO;
      tcnt           <= '0;
      bus.key_ack    <= 1'b0;
      bus.alu_ack    <= 1'b0;
      bus.cv_convert <= 1'b0;
      bus.cv_num     <= '0;
    end else begin
      bus.key_ack    <= 1'b0;
      bus.alu_ack    <= 1'b0;
      bus.cv_convert <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            if (grant_alu && bus.alu_err) begin
              bus.alu_ack <= 1'b1;
              shown       <= WORD_ERR;
            end else begin
              state          <= ISSUE;
              bus.cv_convert <= 1'b1;
              last_grant     <= grant_alu;
              if (grant_alu) begin
                bus.alu_ack <= 1'b1;
                bus.cv_num  <= bus.alu_num;
              end else begin
                bus.key_ack <= 1'b1;
                bus.cv_num  <= bus.key_num;
              end
            end
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.cv_done) begin
            shown <= bus.cv_digits;
            state <= IDLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            shown <= WORD_DASH;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A digit is blank when it and every more-significant digit read "0".
  always_comb begin
    blank    = 4'b0000;
    blank[3] = BLANK_LZ && (shown[31:24] == SEG_ZERO);
    blank[2] = blank[3] && (shown[23:16] == SEG_ZERO);
    blank[1] = blank[2] && (shown[15:8]  == SEG_ZERO);
    digit    = shown[{idx, 3'b000} +: 8];
    seg_cur  = blank[idx] ? 8'h00 : {1'b0, digit[6:0]};
  end

  // idx names the slot presented at the next wrap, so the first slot after
  // reset lights digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
      seg <= 8'h00;
      an  <= 4'hF;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      an  <= ~(4'b0001 << idx);
      seg <= seg_cur;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_disp_ctrl.sv
// Scoreboard bench for disp_ctrl: stimulus queues expected acks and scan
// slots, independent monitors pop and compare as the DUT presents them.
module tb_disp_ctrl;
  localparam int unsigned SD = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_ctrl_if bus();
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy;

  disp_ctrl #(.SCAN_DIV(SD), .TIMEOUT(TO), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg), .an(an), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  typedef struct {bit is_alu; bit conv; logic [13:0] num;} ack_t;
  typedef struct {logic [3:0] an; logic [7:0] seg;} slot_t;
  ack_t  ack_q[$];
  slot_t slot_q[$];

  // Converter model: answers each convert with conv_word after conv_delay.
  bit          conv_en = 1'b1;
  int          conv_delay = 12;
  logic [31:0] conv_word = '0;
  initial begin
    bus.cv_done = 1'b0;
    bus.cv_digits = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cv_convert && conv_en) begin
        repeat (conv_delay - 1) @(negedge clk);
        bus.cv_digits = conv_word;
        bus.cv_done = 1'b1;
        @(negedge clk);
        bus.cv_done = 1'b0;
      end
    end
  end

  // Ack/convert monitor.
  ack_t ea;
  initial forever begin
    @(negedge clk);
    if (rst_n && (bus.key_ack || bus.alu_ack || bus.cv_convert)) begin
      if (ack_q.size() == 0) fail("unexpected_ack_or_convert");
      else begin
        ea = ack_q.pop_front();
        check("ack_sel", {30'd0, bus.alu_ack, bus.key_ack}, ea.is_alu ? 32'd2 : 32'd1);
        check("cv_convert", bus.cv_convert, ea.conv);
        if (ea.conv) check("cv_num", bus.cv_num, ea.num);
        check("cv_error", bus.cv_error, 1'b0);
      end
    end
  end

  // Scan monitor: compares each new slot while expectations are queued.
  logic [3:0] prev_an;
  slot_t      es;
  initial forever begin
    @(negedge clk);
    if (rst_n && an !== prev_an && slot_q.size() > 0) begin
      es = slot_q.pop_front();
      check("scan_an", an, es.an);
      check("scan_seg", seg, es.seg);
    end
    prev_an = an;
  end

  task automatic do_req(input bit is_alu, input logic [13:0] num, input bit err);
    if (is_alu) begin
      bus.alu_num = num; bus.alu_err = err; bus.alu_req = 1'b1;
    end else begin
      bus.key_num = num; bus.key_req = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_alu ? bus.alu_ack : bus.key_ack) begin
        if (is_alu) begin bus.alu_req = 1'b0; bus.alu_err = 1'b0; end
        else bus.key_req = 1'b0;
        return;
      end
    end
    fail(is_alu ? "alu_ack_timeout" : "key_ack_timeout");
    bus.alu_req = 1'b0; bus.key_req = 1'b0; bus.alu_err = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    fail("busy_stuck");
  endtask

  task automatic check_display(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
    int i;
    for (i = 0; i < int'(8 * SD + 8); i++) begin
      if (an == 4'b0111) break;
      @(negedge clk);
    end
    if (an != 4'b0111) begin fail("scan_sync_timeout"); return; end
    @(negedge clk);
    slot_q.push_back('{4'b1110, d0});
    slot_q.push_back('{4'b1101, d1});
    slot_q.push_back('{4'b1011, d2});
    slot_q.push_back('{4'b0111, d3});
    for (i = 0; i < int'(8 * SD + 8); i++) begin
      if (slot_q.size() == 0) return;
      @(negedge clk);
    end
    fail("scan_drain_timeout");
    slot_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit busy_gap;
  int busy_cycles;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_req = 1'b0; bus.key_num = '0;
    bus.alu_req = 1'b0; bus.alu_num = '0; bus.alu_err = 1'b0;

    // 1: reset values and idle scan of "0000" with leading-zero blanking.
    slot_q.push_back('{4'b1110, 8'h3F});
    slot_q.push_back('{4'b1101, 8'h00});
    slot_q.push_back('{4'b1011, 8'h00});
    slot_q.push_back('{4'b0111, 8'h00});
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {bus.key_ack, bus.alu_ack, bus.cv_convert}, 3'b000);
    check("rst_cv_num", bus.cv_num, 14'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("an_before_first_wrap", an, 4'hF);
    @(negedge clk);
    check("an_first_wrap", an, 4'b1110);
    for (int i = 0; i < 40 && slot_q.size() > 0; i++) @(negedge clk);
    check("idle_scan_drained", slot_q.size(), 0);

    // 2: keypad job 1234.
    conv_word = 32'h065B4F66;
    conv_delay = 12;
    ack_q.push_back('{1'b0, 1'b1, 14'd1234});
    do_req(1'b0, 14'd1234, 1'b0);
    wait_idle();
    check_display(8'h66, 8'h4F, 8'h5B, 8'h06);

    // 3: simultaneous requests from reset: ALU first, busy gap, then keypad.
    pulse_reset();
    ack_q.push_back('{1'b1, 1'b1, 14'd100});
    ack_q.push_back('{1'b0, 1'b1, 14'd200});
    busy_gap = 1'b0;
    fork
      do_req(1'b1, 14'd100, 1'b0);
      do_req(1'b0, 14'd200, 1'b0);
      begin
        int n;
        for (n = 0; n < 200 && !bus.alu_ack; n++) @(negedge clk);
        for (n = 0; n < 200 && !bus.key_ack; n++) begin
          @(negedge clk);
          if (!busy) busy_gap = 1'b1;
        end
      end
    join
    check("busy_gap_between_jobs", busy_gap, 1'b1);
    wait_idle();
    check("rr_acks_consumed", ack_q.size(), 0);

    // 4: ALU error: ack only, error word shown unblanked.
    ack_q.push_back('{1'b1, 1'b0, 14'd0});
    do_req(1'b1, 14'd55, 1'b1);
    check("err_not_busy", busy, 1'b0);
    check_display(8'h7C, 8'h50, 8'h3D, 8'h76);

    // 5: no cv_done: ISSUE + TIMEOUT WAIT cycles then dashes.
    conv_en = 1'b0;
    ack_q.push_back('{1'b0, 1'b1, 14'd42});
    do_req(1'b0, 14'd42, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", busy_cycles, 17);
    check_display(8'h40, 8'h40, 8'h40, 8'h40);
    conv_en = 1'b1;

    // 5b: done in the last WAIT cycle wins over the timeout.
    conv_word = 32'h3F3F3F06;
    conv_delay = 17;
    ack_q.push_back('{1'b0, 1'b1, 14'd1});
    do_req(1'b0, 14'd1, 1'b0);
    wait_idle();
    check_display(8'h06, 8'h00, 8'h00, 8'h00);

    // 6: async reset during WAIT, then a fresh job.
    conv_en = 1'b0;
    ack_q.push_back('{1'b0, 1'b1, 14'd77});
    do_req(1'b0, 14'd77, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 8'h00);
    check("async_rst_cv_num", bus.cv_num, 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv_en = 1'b1;
    conv_delay = 5;
    conv_word = 32'h3F3F5B4F;
    ack_q.push_back('{1'b0, 1'b1, 14'd23});
    do_req(1'b0, 14'd23, 1'b0);
    wait_idle();
    check_display(8'h4F, 8'h5B, 8'h00, 8'h00);

    check("ack_queue_empty", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
